// File: rtl/mem_sched_pkg.sv
// ============================================================================
// Module  : mem_sched_pkg
// Purpose : Shared types and constants for the two-requester SRAM scheduler.
// Contents: state_t    - scheduler FSM state encoding
//           req_id_t   - requester identifier (CPU / LOADER)
//           MMIO_SW_ADDR - address decoded as the switch register when the
//                          MMIO_SW_EN macro is defined
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef enum logic {
    CPU    = 1'b0,
    LOADER = 1'b1
  } req_id_t;

  localparam logic [15:0] MMIO_SW_ADDR = 16'hFFFF;

endpackage

`default_nettype wire

// File: rtl/mem_rr_arb2.sv
// ============================================================================
// Module  : mem_rr_arb2
// Purpose : Two-way round-robin arbiter (combinational).
// Ports   : cpu_req, ld_req - request lines
//           en             - arbitration enable; when low the grant simply
//                            echoes last_grant
//           last_grant     - requester granted most recently
//           grant          - selected requester
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_rr_arb2
  import mem_sched_pkg::*;
(
  input  logic    cpu_req,
  input  logic    ld_req,
  input  logic    en,
  input  req_id_t last_grant,
  output req_id_t grant
);

  always_comb begin
    grant = last_grant;
    if (en) begin
      if (cpu_req && ld_req) begin
        // Tie: the requester that did not win last time goes first.
        grant = (last_grant == CPU) ? LOADER : CPU;
      end else if (cpu_req) begin
        grant = CPU;
      end else if (ld_req) begin
        grant = LOADER;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_sched.sv
// ============================================================================
// Module  : mem_sched
// Purpose : Schedules CPU and loader transactions onto one asynchronous SRAM.
//           IDLE -> SETUP (1) -> ACCESS (WAIT_CYCLES) -> DONE (1) -> IDLE.
//           All SRAM strobes, ADDR and ready/rdata are registered.
// Params  : WAIT_CYCLES - SRAM access cycles per transaction (1..15)
// Ports   : Clk, Reset (sync, active low)
//           cpu_req/we/addr/wdata -> cpu_rdata, cpu_ready
//           ld_req/we/addr/wdata  -> ld_rdata, ld_ready
//           S     - switch value (memory-mapped read)
//           ADDR  - SRAM address, Data - SRAM bidirectional data bus
//           CE, UB, LB, OE, WE - active-low SRAM strobes
// Config  : MMIO_SW_EN - when defined, address 16'hFFFF maps to the switch
//           input S instead of SRAM; writes there are dropped.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_sched
  import mem_sched_pkg::*;
#(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_ready,
  input  logic        ld_req,
  input  logic        ld_we,
  input  logic [15:0] ld_addr,
  input  logic [15:0] ld_wdata,
  output logic [15:0] ld_rdata,
  output logic        ld_ready,
  input  logic [15:0] S,
  output logic [15:0] ADDR,
  inout  wire  [15:0] Data,
  output logic        CE,
  output logic        UB,
  output logic        LB,
  output logic        OE,
  output logic        WE
);

  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  state_t      state;
  logic [3:0]  cnt;
  req_id_t     gnt_q;
  req_id_t     last_grant;
  logic        we_q;
  logic [15:0] wdata_q;
  logic        hit_q;
  logic        drive;

  req_id_t     grant;
  logic        sel_we;
  logic [15:0] sel_addr;
  logic [15:0] sel_wdata;
  logic        sel_hit;
  logic [15:0] rd_src;

  mem_rr_arb2 u_arb (
    .cpu_req    (cpu_req),
    .ld_req     (ld_req),
    .en         (state == IDLE),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign sel_we    = (grant == CPU) ? cpu_we    : ld_we;
  assign sel_addr  = (grant == CPU) ? cpu_addr  : ld_addr;
  assign sel_wdata = (grant == CPU) ? cpu_wdata : ld_wdata;

`ifdef MMIO_SW_EN
  assign sel_hit = (sel_addr == MMIO_SW_ADDR);
  assign rd_src  = hit_q ? S : Data;
`else
  logic unused_s;
  assign sel_hit  = 1'b0;
  assign rd_src   = Data;
  assign unused_s = ^S;
`endif

  assign Data = drive ? wdata_q : 16'hzzzz;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      gnt_q      <= CPU;
      last_grant <= LOADER;
      we_q       <= 1'b0;
      wdata_q    <= 16'h0000;
      hit_q      <= 1'b0;
      drive      <= 1'b0;
      cpu_rdata  <= 16'h0000;
      ld_rdata   <= 16'h0000;
      cpu_ready  <= 1'b0;
      ld_ready   <= 1'b0;
      ADDR       <= 16'h0000;
      CE         <= 1'b1;
      UB         <= 1'b1;
      LB         <= 1'b1;
      OE         <= 1'b1;
      WE         <= 1'b1;
    end else begin
      cpu_ready <= 1'b0;
      ld_ready  <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req || ld_req) begin
            state      <= SETUP;
            gnt_q      <= grant;
            last_grant <= grant;
            we_q       <= sel_we;
            wdata_q    <= sel_wdata;
            hit_q      <= sel_hit;
            ADDR       <= sel_addr;
            // A switch-register hit leaves the SRAM completely untouched.
            CE         <= sel_hit;
            UB         <= sel_hit;
            LB         <= sel_hit;
            OE         <= sel_we | sel_hit;
            drive      <= sel_we & ~sel_hit;
          end
        end
        SETUP: begin
          state <= ACCESS;
          cnt   <= 4'd0;
          WE    <= ~(we_q & ~hit_q);
        end
        ACCESS: begin
          if (cnt == LAST_CNT) begin
            state <= DONE;
            CE    <= 1'b1;
            UB    <= 1'b1;
            LB    <= 1'b1;
            OE    <= 1'b1;
            WE    <= 1'b1;
            // Read data is sampled while the SRAM is still enabled.
            if (gnt_q == CPU) begin
              cpu_ready <= 1'b1;
              if (!we_q) cpu_rdata <= rd_src;
            end else begin
              ld_ready <= 1'b1;
              if (!we_q) ld_rdata <= rd_src;
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DONE: begin
          // Write data is held through DONE so it is stable past WE rising.
          state <= IDLE;
          ADDR  <= 16'h0000;
          drive <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_sched.sv
// ============================================================================
// Module  : tb_mem_sched
// Purpose : Scoreboard bench for mem_sched (WAIT_CYCLES = 2) with a simple
//           SRAM model. Build with MMIO_SW_EN defined to cover the switch
//           register path.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_sched;
  import mem_sched_pkg::*;

  localparam int W = 2;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [15:0] cpu_addr = 16'h0, cpu_wdata = 16'h0;
  logic [15:0] cpu_rdata;
  logic        cpu_ready;
  logic        ld_req = 1'b0, ld_we = 1'b0;
  logic [15:0] ld_addr = 16'h0, ld_wdata = 16'h0;
  logic [15:0] ld_rdata;
  logic        ld_ready;
  logic [15:0] S = 16'h0;
  logic [15:0] ADDR;
  wire  [15:0] Data;
  logic        CE, UB, LB, OE, WE;

  mem_sched #(.WAIT_CYCLES(W)) dut (
    .Clk(Clk), .Reset(Reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr),
    .ld_wdata(ld_wdata), .ld_rdata(ld_rdata), .ld_ready(ld_ready),
    .S(S), .ADDR(ADDR), .Data(Data),
    .CE(CE), .UB(UB), .LB(LB), .OE(OE), .WE(WE)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc++;

  // SRAM model: low byte of ADDR selects a word.
  logic [15:0] mem [256];
  assign Data = (!CE && !OE && WE) ? mem[ADDR[7:0]] : 16'hzzzz;
  always @(posedge Clk) if (!CE && !WE) mem[ADDR[7:0]] <= Data;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    req_id_t     id;
    logic        rd;
    logic [15:0] data;
    int          due;
  } exp_t;
  exp_t q[$];

  // Strobe activity counters, cleared at the start of each transaction.
  int oe_n, we_n, ce_n, d_n;
  logic [15:0] d_val;
  always @(negedge Clk) begin
    if (!OE) oe_n++;
    if (!WE) we_n++;
    if (!CE) ce_n++;
    if (Data === d_val) d_n++;
  end

  // Monitor: every ready pulse must match the oldest queued expectation.
  always @(negedge Clk) begin
    if (Reset) begin
      if (cpu_ready && ld_ready) begin
        chk("both_ready", 32'(cpu_ready & ld_ready), 32'd0);
      end else if (cpu_ready || ld_ready) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_ready: cpu=%0b ld=%0b expected none (cycle %0d)",
                   cpu_ready, ld_ready, cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("grant_id", 32'(ld_ready), 32'(e.id));
          chk("ready_cycle", 32'(cyc), 32'(e.due));
          if (e.rd) chk("rdata", 32'(ld_ready ? ld_rdata : cpu_rdata), 32'(e.data));
        end
      end
    end
  end

  // Issue one transaction from IDLE (called at a falling edge) and wait for
  // its ready. Grant happens at the next rising edge; ready follows W+1 edges later.
  task automatic txn(input req_id_t id, input logic we, input logic [15:0] addr,
                     input logic [15:0] wdata, input logic [15:0] exp,
                     input bit drop_early);
    bit done = 0;
    oe_n = 0; we_n = 0; ce_n = 0; d_n = 0;
    if (id == CPU) begin
      cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    end else begin
      ld_req = 1; ld_we = we; ld_addr = addr; ld_wdata = wdata;
    end
    q.push_back('{id: id, rd: !we, data: exp, due: cyc + W + 2});
    if (drop_early) begin
      @(posedge Clk);
      @(negedge Clk);
      cpu_req = 0; ld_req = 0;
    end
    for (int i = 0; i < 30 && !done; i++) begin
      @(negedge Clk);
      if ((id == CPU && cpu_ready) || (id == LOADER && ld_ready)) done = 1;
    end
    if (!done) chk("ready_timeout", 32'd0, 32'd1);
    cpu_req = 0; ld_req = 0;
    @(negedge Clk);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h10] = 16'hBEEF;
    mem[8'hFF] = 16'h7777;
    d_val = 'x;

    // Reset state
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    chk("rst_cpu_ready", 32'(cpu_ready), 32'd0);
    chk("rst_ld_ready",  32'(ld_ready),  32'd0);
    chk("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
    chk("rst_addr",      32'(ADDR),      32'd0);
    chk("rst_strobes",   32'({CE, UB, LB, OE, WE}), 32'h1F);
    chk("rst_data_z",    32'(Data === 16'hzzzz), 32'd1);
    Reset = 1;
    @(negedge Clk);

    // CPU read from SRAM
    txn(CPU, 1'b0, 16'h0010, 16'h0, 16'hBEEF, 0);
    chk("rd_oe_low_cycles", 32'(oe_n), 32'd3);
    chk("rd_we_low_cycles", 32'(we_n), 32'd0);
    chk("rd_ce_low_cycles", 32'(ce_n), 32'd3);

    // Loader write
    d_val = 16'h1234;
    txn(LOADER, 1'b1, 16'h0020, 16'h1234, 16'h0, 0);
    chk("wr_we_low_cycles", 32'(we_n), 32'd2);
    chk("wr_oe_low_cycles", 32'(oe_n), 32'd0);
    chk("wr_data_cycles",   32'(d_n),  32'd4);
    chk("wr_mem",           32'(mem[8'h20]), 32'h1234);
    chk("cpu_rdata_hold",   32'(cpu_rdata),  32'hBEEF);
    d_val = 'x;

    // CPU read with request dropped during SETUP
    txn(CPU, 1'b0, 16'h0020, 16'h0, 16'h1234, 1);

    // Address 16'hFFFF: switch register or plain SRAM
    S = 16'h00A5;
`ifdef MMIO_SW_EN
    txn(CPU, 1'b0, 16'hFFFF, 16'h0, 16'h00A5, 0);
    chk("mmio_ce_low_cycles", 32'(ce_n), 32'd0);
    chk("mmio_oe_low_cycles", 32'(oe_n), 32'd0);
    mem[8'hFF] = 16'h7777;
    txn(LOADER, 1'b1, 16'hFFFF, 16'h9999, 16'h0, 0);
    chk("mmio_wr_dropped", 32'(mem[8'hFF]), 32'h7777);
`else
    txn(CPU, 1'b0, 16'hFFFF, 16'h0, 16'h7777, 0);
    chk("ffff_ce_low_cycles", 32'(ce_n), 32'd3);
`endif

    // Reset during ACCESS of a loader write
    ld_req = 1; ld_we = 1; ld_addr = 16'h0040; ld_wdata = 16'hCAFE;
    @(posedge Clk);  // grant -> SETUP
    @(posedge Clk);  // -> ACCESS
    @(negedge Clk);
    chk("pre_rst_we_low", 32'(WE), 32'd0);
    Reset = 0; ld_req = 0;
    @(negedge Clk);
    chk("mid_rst_strobes", 32'({CE, WE, OE}), 32'h7);
    chk("mid_rst_data_z",  32'(Data === 16'hzzzz), 32'd1);
    chk("mid_rst_addr",    32'(ADDR), 32'd0);
    chk("mid_rst_rdata",   32'(cpu_rdata), 32'd0);
    Reset = 1;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      n += int'(cpu_ready) + int'(ld_ready);
    end
    chk("no_ready_after_rst", 32'(n), 32'd0);

    // Both requesting from reset release: CPU, loader, CPU, loader
    Reset = 0;
    @(negedge Clk);
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
    ld_req = 1;  ld_we = 0;  ld_addr = 16'h0020;
    Reset = 1;
    for (int i = 0; i < 4; i++)
      q.push_back('{id: (i % 2 == 0) ? CPU : LOADER, rd: 1'b1,
                    data: (i % 2 == 0) ? 16'hBEEF : 16'h1234,
                    due: cyc + W + 2 + i * (W + 3)});
    n = 0;
    for (int i = 0; i < 60 && n < 4; i++) begin
      @(negedge Clk);
      n += int'(cpu_ready) + int'(ld_ready);
    end
    cpu_req = 0; ld_req = 0;
    chk("tie_ready_count", 32'(n), 32'd4);
    repeat (4) @(negedge Clk);
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
